// File: rtl/ccip_hazard_tracker_pkg.sv
// ccip_hazard_tracker_pkg: widths, event flag bit indices and record types shared by the hazard tracker.
package ccip_hazard_tracker_pkg;
    localparam int ADDR_W = 42;
    localparam int MDATA_W = 16;
    localparam int TS_W = 32;
    localparam int NFLAGS = 6;
    localparam int EVT_HAZ_RD = 0;
    localparam int EVT_HAZ_WR = 1;
    localparam int EVT_SAME_CYC = 2;
    localparam int EVT_ORPHAN_RSP = 3;
    localparam int EVT_DUP_MDATA = 4;
    localparam int EVT_TBL_FULL = 5;

    typedef struct packed {
        logic [NFLAGS-1:0]  flags;
        logic [ADDR_W-1:0]  c0_addr;
        logic [ADDR_W-1:0]  c1_addr;
        logic [MDATA_W-1:0] c0_mdata;
        logic [MDATA_W-1:0] c1_mdata;
        logic [TS_W-1:0]    cycle;
    } ccip_evt_t;

    typedef struct packed {
        logic               valid;
        logic               is_wr;
        logic [ADDR_W-1:0]  addr;
        logic [MDATA_W-1:0] mdata;
    } trk_entry_t;
endpackage

// File: rtl/ccip_hazard_tracker_if.sv
// ccip_hazard_tracker_if: CCI-P request/response taps and the event record stream of the hazard tracker.
interface ccip_hazard_tracker_if #(parameter int DEPTH = 64);
    import ccip_hazard_tracker_pkg::*;
    logic               c0tx_valid;
    logic [ADDR_W-1:0]  c0tx_addr;
    logic [MDATA_W-1:0] c0tx_mdata;
    logic               c1tx_valid;
    logic [ADDR_W-1:0]  c1tx_addr;
    logic [MDATA_W-1:0] c1tx_mdata;
    logic               c0rx_valid;
    logic [MDATA_W-1:0] c0rx_mdata;
    logic               c1rx_valid;
    logic [MDATA_W-1:0] c1rx_mdata;
    logic               evt_valid;
    logic               evt_ready;
    logic [NFLAGS-1:0]  evt_flags;
    logic [ADDR_W-1:0]  evt_c0_addr;
    logic [ADDR_W-1:0]  evt_c1_addr;
    logic [MDATA_W-1:0] evt_c0_mdata;
    logic [MDATA_W-1:0] evt_c1_mdata;
    logic [TS_W-1:0]    evt_cycle;
    logic [$clog2(DEPTH):0] outst_rd;
    logic [$clog2(DEPTH):0] outst_wr;
    logic               evt_dropped;

    modport master (
        output c0tx_valid, c0tx_addr, c0tx_mdata, c1tx_valid, c1tx_addr, c1tx_mdata,
               c0rx_valid, c0rx_mdata, c1rx_valid, c1rx_mdata, evt_ready,
        input  evt_valid, evt_flags, evt_c0_addr, evt_c1_addr, evt_c0_mdata, evt_c1_mdata,
               evt_cycle, outst_rd, outst_wr, evt_dropped
    );
    modport slave (
        input  c0tx_valid, c0tx_addr, c0tx_mdata, c1tx_valid, c1tx_addr, c1tx_mdata,
               c0rx_valid, c0rx_mdata, c1rx_valid, c1rx_mdata, evt_ready,
        output evt_valid, evt_flags, evt_c0_addr, evt_c1_addr, evt_c0_mdata, evt_c1_mdata,
               evt_cycle, outst_rd, outst_wr, evt_dropped
    );
endinterface

// File: rtl/ccip_hazard_tracker_evt_fifo.sv
// ccip_hazard_tracker_evt_fifo: event record FIFO with valid/ready drain and a sticky drop flag.
module ccip_hazard_tracker_evt_fifo
    import ccip_hazard_tracker_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      sys_reset_n,
    input  logic      push,
    input  ccip_evt_t din,
    input  logic      ready,
    output logic      valid,
    output ccip_evt_t dout,
    output logic      dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    ccip_evt_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic full, pop, wr;

    assign valid = cnt != '0;
    assign full = cnt == CW'(DEPTH);
    assign pop = valid & ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign wr = push & (~full | pop);
    assign dout = valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (!sys_reset_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            dropped <= 1'b0;
        end else begin
            if (wr)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
            cnt <= cnt + CW'(wr) - CW'(pop);
            if (push && !wr)
                dropped <= 1'b1;
        end
    end
endmodule

// File: rtl/ccip_hazard_tracker.sv
// ccip_hazard_tracker: tracks outstanding CCI-P reads/writes by mdata and logs hazard/protocol events.
module ccip_hazard_tracker
    import ccip_hazard_tracker_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int EVT_DEPTH = 16
) (
    input logic clk,
    input logic sys_reset_n,
    ccip_hazard_tracker_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    trk_entry_t tbl [DEPTH];
    logic [IW-1:0] f0, f1, r0, r1, a1_idx;
    logic has0, has1, hit0, hit1, haz0, haz1, dup0, dup1;
    logic a0, a1, a1_has, fr0, fr1, o0, o1;
    logic [NFLAGS-1:0] flags;
    logic [CW-1:0] rd_cnt, wr_cnt;
    logic [TS_W-1:0] cycle;
    ccip_evt_t rec, head;

    // descending scan so the lowest matching/free index is the one left standing
    always_comb begin
        {haz0, haz1, dup0, dup1, has0, has1, hit0, hit1} = '0;
        {f0, f1, r0, r1} = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl[i].valid) begin
                haz0 |= tbl[i].addr == bus.c0tx_addr;
                haz1 |= tbl[i].addr == bus.c1tx_addr;
                dup0 |= !tbl[i].is_wr && tbl[i].mdata == bus.c0tx_mdata;
                dup1 |= tbl[i].is_wr && tbl[i].mdata == bus.c1tx_mdata;
                if (!tbl[i].is_wr && tbl[i].mdata == bus.c0rx_mdata) begin
                    r0 = IW'(i);
                    hit0 = 1'b1;
                end
                if (tbl[i].is_wr && tbl[i].mdata == bus.c1rx_mdata) begin
                    r1 = IW'(i);
                    hit1 = 1'b1;
                end
            end else begin
                f1 = f0;
                has1 = has0;
                f0 = IW'(i);
                has0 = 1'b1;
            end
        end
        a1_idx = bus.c0tx_valid ? f1 : f0;
        a1_has = bus.c0tx_valid ? has1 : has0;
        a0 = bus.c0tx_valid & has0;
        a1 = bus.c1tx_valid & a1_has;
        fr0 = bus.c0rx_valid & hit0;
        fr1 = bus.c1rx_valid & hit1;
        o0 = bus.c0rx_valid & ~hit0;
        o1 = bus.c1rx_valid & ~hit1;
        flags = '0;
        flags[EVT_HAZ_RD] = bus.c0tx_valid & haz0;
        flags[EVT_HAZ_WR] = bus.c1tx_valid & haz1;
        flags[EVT_SAME_CYC] = bus.c0tx_valid & bus.c1tx_valid & (bus.c0tx_addr == bus.c1tx_addr);
        flags[EVT_ORPHAN_RSP] = o0 | o1;
        flags[EVT_DUP_MDATA] = (bus.c0tx_valid & dup0) | (bus.c1tx_valid & dup1);
        flags[EVT_TBL_FULL] = (bus.c0tx_valid & ~has0) | (bus.c1tx_valid & ~a1_has);
        rec.flags = flags;
        rec.c0_addr = bus.c0tx_valid ? bus.c0tx_addr : '0;
        rec.c1_addr = bus.c1tx_valid ? bus.c1tx_addr : '0;
        rec.c0_mdata = o0 ? bus.c0rx_mdata : bus.c0tx_valid ? bus.c0tx_mdata : '0;
        rec.c1_mdata = o1 ? bus.c1rx_mdata : bus.c1tx_valid ? bus.c1tx_mdata : '0;
        rec.cycle = cycle;
    end

    always_ff @(posedge clk) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i].valid <= 1'b0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            cycle <= '0;
        end else begin
            cycle <= cycle + TS_W'(1);
            if (fr0)
                tbl[r0].valid <= 1'b0;
            if (fr1)
                tbl[r1].valid <= 1'b0;
            if (a0)
                tbl[f0] <= '{valid: 1'b1, is_wr: 1'b0, addr: bus.c0tx_addr, mdata: bus.c0tx_mdata};
            if (a1)
                tbl[a1_idx] <= '{valid: 1'b1, is_wr: 1'b1, addr: bus.c1tx_addr, mdata: bus.c1tx_mdata};
            rd_cnt <= rd_cnt + CW'(a0) - CW'(fr0);
            wr_cnt <= wr_cnt + CW'(a1) - CW'(fr1);
        end
    end

    ccip_hazard_tracker_evt_fifo #(.DEPTH(EVT_DEPTH)) u_fifo (
        .clk(clk),
        .sys_reset_n(sys_reset_n),
        .push(|flags),
        .din(rec),
        .ready(bus.evt_ready),
        .valid(bus.evt_valid),
        .dout(head),
        .dropped(bus.evt_dropped)
    );

    assign bus.evt_flags = head.flags;
    assign bus.evt_c0_addr = head.c0_addr;
    assign bus.evt_c1_addr = head.c1_addr;
    assign bus.evt_c0_mdata = head.c0_mdata;
    assign bus.evt_c1_mdata = head.c1_mdata;
    assign bus.evt_cycle = head.cycle;
    assign bus.outst_rd = rd_cnt;
    assign bus.outst_wr = wr_cnt;
endmodule

// File: tb/tb_ccip_hazard_tracker.sv
// tb_ccip_hazard_tracker: vector table, directed corner sequences and random traffic against a slot-map model.
module tb_ccip_hazard_tracker;
    import ccip_hazard_tracker_pkg::*;
    localparam int DEPTH = 64;
    localparam int EVT_DEPTH = 16;

    logic clk = 1'b0;
    logic sys_reset_n = 1'b0;
    always #5 clk = ~clk;

    ccip_hazard_tracker_if #(.DEPTH(DEPTH)) bus();
    ccip_hazard_tracker #(.DEPTH(DEPTH), .EVT_DEPTH(EVT_DEPTH)) dut (
        .clk(clk),
        .sys_reset_n(sys_reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // model: slot index -> outstanding request; FIFO as a bounded queue
    typedef struct {
        bit                 wr;
        logic [ADDR_W-1:0]  addr;
        logic [MDATA_W-1:0] mdata;
    } ment_t;
    ment_t slots [int];
    ccip_evt_t evq [$];
    bit m_drop;
    logic [TS_W-1:0] m_cycle;

    function automatic int lowest_free(int skip);
        int r = -1;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (!slots.exists(k) && k != skip) r = k;
        return r;
    endfunction

    function automatic int find_rsp(bit wr, logic [MDATA_W-1:0] md);
        int r = -1;
        foreach (slots[k])
            if (r < 0 && slots[k].wr == wr && slots[k].mdata == md) r = k;
        return r;
    endfunction

    function automatic bit addr_hit(logic [ADDR_W-1:0] a);
        bit h = 0;
        foreach (slots[k])
            if (slots[k].addr == a) h = 1;
        return h;
    endfunction

    function automatic int n_of(bit wr);
        int n = 0;
        foreach (slots[k])
            if (slots[k].wr == wr) n++;
        return n;
    endfunction

    task automatic model_step();
        ccip_evt_t e;
        int s0, s1, k0, k1;
        bit pop, full;
        if (!sys_reset_n) begin
            slots.delete();
            evq.delete();
            m_drop = 0;
            m_cycle = '0;
            return;
        end
        e = '0;
        if (bus.c0tx_valid) begin
            e.c0_addr = bus.c0tx_addr;
            e.c0_mdata = bus.c0tx_mdata;
            if (addr_hit(bus.c0tx_addr)) e.flags[EVT_HAZ_RD] = 1'b1;
            if (find_rsp(0, bus.c0tx_mdata) >= 0) e.flags[EVT_DUP_MDATA] = 1'b1;
        end
        if (bus.c1tx_valid) begin
            e.c1_addr = bus.c1tx_addr;
            e.c1_mdata = bus.c1tx_mdata;
            if (addr_hit(bus.c1tx_addr)) e.flags[EVT_HAZ_WR] = 1'b1;
            if (find_rsp(1, bus.c1tx_mdata) >= 0) e.flags[EVT_DUP_MDATA] = 1'b1;
        end
        if (bus.c0tx_valid && bus.c1tx_valid && bus.c0tx_addr == bus.c1tx_addr)
            e.flags[EVT_SAME_CYC] = 1'b1;
        s0 = bus.c0tx_valid ? lowest_free(-1) : -1;
        s1 = bus.c1tx_valid ? lowest_free(s0) : -1;
        if ((bus.c0tx_valid && s0 < 0) || (bus.c1tx_valid && s1 < 0))
            e.flags[EVT_TBL_FULL] = 1'b1;
        k0 = bus.c0rx_valid ? find_rsp(0, bus.c0rx_mdata) : -1;
        k1 = bus.c1rx_valid ? find_rsp(1, bus.c1rx_mdata) : -1;
        if (bus.c0rx_valid && k0 < 0) begin
            e.flags[EVT_ORPHAN_RSP] = 1'b1;
            e.c0_mdata = bus.c0rx_mdata;
        end
        if (bus.c1rx_valid && k1 < 0) begin
            e.flags[EVT_ORPHAN_RSP] = 1'b1;
            e.c1_mdata = bus.c1rx_mdata;
        end
        e.cycle = m_cycle;
        full = evq.size() == EVT_DEPTH;
        pop = evq.size() > 0 && bus.evt_ready;
        if (pop) void'(evq.pop_front());
        if (e.flags != '0) begin
            if (!full || pop) evq.push_back(e);
            else m_drop = 1;
        end
        if (k0 >= 0) slots.delete(k0);
        if (k1 >= 0) slots.delete(k1);
        if (s0 >= 0) slots[s0] = '{wr: 1'b0, addr: bus.c0tx_addr, mdata: bus.c0tx_mdata};
        if (s1 >= 0) slots[s1] = '{wr: 1'b1, addr: bus.c1tx_addr, mdata: bus.c1tx_mdata};
        m_cycle = m_cycle + 1;
    endtask

    task automatic check_model();
        chk("m.evt_valid", bus.evt_valid, evq.size() > 0);
        if (evq.size() > 0) begin
            chk("m.flags", bus.evt_flags, evq[0].flags);
            chk("m.c0_addr", bus.evt_c0_addr, evq[0].c0_addr);
            chk("m.c1_addr", bus.evt_c1_addr, evq[0].c1_addr);
            chk("m.c0_mdata", bus.evt_c0_mdata, evq[0].c0_mdata);
            chk("m.c1_mdata", bus.evt_c1_mdata, evq[0].c1_mdata);
            chk("m.cycle", bus.evt_cycle, evq[0].cycle);
        end
        chk("m.outst_rd", bus.outst_rd, n_of(0));
        chk("m.outst_wr", bus.outst_wr, n_of(1));
        chk("m.dropped", bus.evt_dropped, m_drop);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        bus.c0tx_valid = 0; bus.c0tx_addr = '0; bus.c0tx_mdata = '0;
        bus.c1tx_valid = 0; bus.c1tx_addr = '0; bus.c1tx_mdata = '0;
        bus.c0rx_valid = 0; bus.c0rx_mdata = '0;
        bus.c1rx_valid = 0; bus.c1rx_mdata = '0;
    endtask

    task automatic do_reset();
        idle();
        sys_reset_n = 0;
        tick();
        sys_reset_n = 1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".evt_valid"}, bus.evt_valid, 0);
        chk({tag, ".flags"}, bus.evt_flags, 0);
        chk({tag, ".c0_addr"}, bus.evt_c0_addr, 0);
        chk({tag, ".c1_addr"}, bus.evt_c1_addr, 0);
        chk({tag, ".c0_mdata"}, bus.evt_c0_mdata, 0);
        chk({tag, ".c1_mdata"}, bus.evt_c1_mdata, 0);
        chk({tag, ".cycle"}, bus.evt_cycle, 0);
        chk({tag, ".outst_rd"}, bus.outst_rd, 0);
        chk({tag, ".outst_wr"}, bus.outst_wr, 0);
        chk({tag, ".dropped"}, bus.evt_dropped, 0);
    endtask

    typedef struct {
        logic c0v; logic [ADDR_W-1:0] c0a; logic [MDATA_W-1:0] c0m;
        logic c1v; logic [ADDR_W-1:0] c1a; logic [MDATA_W-1:0] c1m;
        logic r0v; logic [MDATA_W-1:0] r0m;
        logic r1v; logic [MDATA_W-1:0] r1m;
        int ex_rd; int ex_wr; logic ex_v; logic [NFLAGS-1:0] ex_f;
    } vec_t;
    vec_t vt [17];

    initial begin
        vt[0]  = '{1, 'h100, 5,  0, 0, 0,      0, 0,  0, 0,     1, 0, 0, 'h00};
        vt[1]  = '{0, 0, 0,      0, 0, 0,      0, 0,  0, 0,     1, 0, 0, 'h00};
        vt[2]  = '{0, 0, 0,      0, 0, 0,      0, 0,  0, 0,     1, 0, 0, 'h00};
        vt[3]  = '{0, 0, 0,      0, 0, 0,      1, 5,  0, 0,     0, 0, 0, 'h00};
        vt[4]  = '{1, 'h200, 1,  0, 0, 0,      0, 0,  0, 0,     1, 0, 0, 'h00};
        vt[5]  = '{0, 0, 0,      1, 'h200, 2,  0, 0,  0, 0,     1, 1, 1, 'h02};
        vt[6]  = '{0, 0, 0,      0, 0, 0,      0, 0,  0, 0,     1, 1, 0, 'h00};
        vt[7]  = '{1, 'h300, 3,  1, 'h300, 4,  0, 0,  0, 0,     2, 2, 1, 'h04};
        vt[8]  = '{0, 0, 0,      0, 0, 0,      0, 0,  1, 'h77,  2, 2, 1, 'h08};
        vt[9]  = '{1, 'h400, 1,  0, 0, 0,      0, 0,  0, 0,     3, 2, 1, 'h10};
        vt[10] = '{0, 0, 0,      0, 0, 0,      1, 1,  0, 0,     2, 2, 0, 'h00};
        vt[11] = '{0, 0, 0,      1, 'h200, 2,  0, 0,  0, 0,     2, 3, 1, 'h12};
        vt[12] = '{1, 'h500, 9,  0, 0, 0,      1, 9,  0, 0,     3, 3, 1, 'h08};
        vt[13] = '{0, 0, 0,      0, 0, 0,      1, 9,  0, 0,     2, 3, 0, 'h00};
        vt[14] = '{0, 0, 0,      0, 0, 0,      0, 0,  1, 2,     2, 2, 0, 'h00};
        vt[15] = '{0, 0, 0,      0, 0, 0,      0, 0,  1, 2,     2, 1, 0, 'h00};
        vt[16] = '{0, 0, 0,      0, 0, 0,      0, 0,  1, 2,     2, 1, 1, 'h08};

        bus.evt_ready = 1;
        do_reset();
        do_reset();
        chk_zero("reset");

        for (int i = 0; i < 17; i++) begin
            bus.c0tx_valid = vt[i].c0v; bus.c0tx_addr = vt[i].c0a; bus.c0tx_mdata = vt[i].c0m;
            bus.c1tx_valid = vt[i].c1v; bus.c1tx_addr = vt[i].c1a; bus.c1tx_mdata = vt[i].c1m;
            bus.c0rx_valid = vt[i].r0v; bus.c0rx_mdata = vt[i].r0m;
            bus.c1rx_valid = vt[i].r1v; bus.c1rx_mdata = vt[i].r1m;
            tick();
            chk($sformatf("vec%0d.outst_rd", i), bus.outst_rd, vt[i].ex_rd);
            chk($sformatf("vec%0d.outst_wr", i), bus.outst_wr, vt[i].ex_wr);
            chk($sformatf("vec%0d.evt_valid", i), bus.evt_valid, vt[i].ex_v);
            chk($sformatf("vec%0d.flags", i), bus.evt_flags, vt[i].ex_f);
            if (i == 5) chk("vec5.c1_addr", bus.evt_c1_addr, 'h200);
            if (i == 8) chk("vec8.c1_mdata", bus.evt_c1_mdata, 'h77);
            if (i == 12) chk("vec12.c0_mdata", bus.evt_c0_mdata, 9);
        end

        // table full, and a slot freed this cycle is not reusable until the next
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            bus.c0tx_valid = 1; bus.c0tx_addr = 'h1000 + i; bus.c0tx_mdata = i[15:0];
            tick();
        end
        chk("full.outst_rd", bus.outst_rd, 64);
        chk("full.quiet", bus.evt_valid, 0);
        bus.c0tx_addr = 'h2000; bus.c0tx_mdata = 'h999;
        tick();
        chk("full.flags", bus.evt_flags, 'h20);
        chk("full.outst_rd65", bus.outst_rd, 64);
        bus.c0tx_addr = 'h3000; bus.c0tx_mdata = 'h500;
        bus.c0rx_valid = 1; bus.c0rx_mdata = 0;
        tick();
        chk("reuse.flags", bus.evt_flags, 'h20);
        chk("reuse.outst_rd", bus.outst_rd, 63);
        bus.c0rx_valid = 0;
        tick();
        chk("reuse.alloc", bus.outst_rd, 64);
        chk("reuse.quiet", bus.evt_valid, 0);

        // overflow the event FIFO, push+pop while full, then reset with records held
        do_reset();
        bus.evt_ready = 0;
        for (int i = 0; i < 17; i++) begin
            idle();
            bus.c1rx_valid = 1; bus.c1rx_mdata = 16'h100 + 16'(i);
            tick();
        end
        chk("ovf.dropped", bus.evt_dropped, 1);
        chk("ovf.valid", bus.evt_valid, 1);
        chk("ovf.head", bus.evt_c1_mdata, 'h100);
        chk("ovf.flags", bus.evt_flags, 'h08);
        bus.evt_ready = 1;
        bus.c1rx_mdata = 'h200;
        tick();
        chk("fullpp.head", bus.evt_c1_mdata, 'h101);
        idle();
        tick();
        chk("pop2.head", bus.evt_c1_mdata, 'h102);
        bus.evt_ready = 0;
        do_reset();
        chk_zero("midreset");

        // random traffic against the model
        bus.evt_ready = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sys_reset_n = ($urandom % 600) != 0;
            bus.c0tx_valid = ($urandom % 3) == 0;
            bus.c0tx_addr = 42'($urandom % 12) << 6;
            bus.c0tx_mdata = 16'($urandom % 6);
            bus.c1tx_valid = ($urandom % 3) == 0;
            bus.c1tx_addr = 42'($urandom % 12) << 6;
            bus.c1tx_mdata = 16'($urandom % 6);
            bus.c0rx_valid = ($urandom % 5) < 2;
            bus.c0rx_mdata = 16'($urandom % 6);
            bus.c1rx_valid = ($urandom % 5) < 2;
            bus.c1rx_mdata = 16'($urandom % 6);
            bus.evt_ready = ((cyc / 150) % 3 == 2) ? 1'b0 : 1'(($urandom % 4) != 0);
            tick();
        end
        sys_reset_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
